// File: rtl/params_pkg.sv
// Shared sizing constants and the sequencer state encoding.
package params_pkg;

  localparam int IC_N          = 2;
  localparam int OC_N          = 2;
  localparam int WINDOW_SIZE   = 2;
  localparam int DATA_WIDTH    = 4;
  localparam int WEIGHT_CYCLES = 4;
  localparam int CALC_CYCLES   = 6;

  localparam int VEC_W = IC_N * WINDOW_SIZE * DATA_WIDTH;
  localparam int LEN_W = $clog2(CALC_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_CALC,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/mvm_seq.sv
// Command sequencer for an MVM engine: streams weight/calc vectors from the source,
// then waits for the matching number of result beats with a bounded drain timer.
module mvm_seq
  import params_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_op_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  input  logic [VEC_W-1:0] src_data_i,
  output logic             mvm_valid_o,
  input  logic             mvm_ready_i,
  output logic             mvm_load_mode_o,
  output logic [IC_N-1:0]  mvm_strobe_o,
  output logic [VEC_W-1:0] mvm_vector_o,
  input  logic             res_valid_i,
  input  logic             res_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             timeout_o,
  output logic             wloaded_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] res_q, res_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             wloaded_q, wloaded_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;

  logic streaming;
  logic beat_fire;
  logic res_fire;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    res_d     = res_q;
    timer_d   = timer_q;
    wloaded_d = wloaded_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;

    streaming       = (state_q == ST_LOAD_W) || (state_q == ST_CALC);
    cmd_ready_o     = (state_q == ST_IDLE);
    mvm_valid_o     = streaming && src_valid_i;
    src_ready_o     = streaming && mvm_ready_i;
    mvm_strobe_o    = mvm_valid_o ? {IC_N{1'b1}} : {IC_N{1'b0}};
    mvm_vector_o    = src_data_i;
    mvm_load_mode_o = (state_q == ST_CALC);

    beat_fire = mvm_valid_o && mvm_ready_i;
    // Results are only meaningful once a calculation has started streaming.
    res_fire  = res_valid_i && res_ready_i &&
                ((state_q == ST_CALC) || (state_q == ST_DRAIN));

    if (res_fire && (res_q != {LEN_W{1'b1}})) res_d = res_q + LEN_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (!cmd_op_i && (cmd_len_i == LEN_W'(WEIGHT_CYCLES))) begin
            state_d   = ST_LOAD_W;
            wloaded_d = 1'b0;
            len_d     = cmd_len_i;
            beat_d    = '0;
            res_d     = '0;
            timer_d   = '0;
          end else if (cmd_op_i && (cmd_len_i != '0) &&
                       (cmd_len_i <= LEN_W'(CALC_CYCLES)) && wloaded_q) begin
            state_d = ST_CALC;
            len_d   = cmd_len_i;
            beat_d  = '0;
            res_d   = '0;
            timer_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD_W: begin
        if (beat_fire) begin
          if ((beat_q + LEN_W'(1)) == len_q) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            wloaded_d = 1'b1;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      ST_CALC: begin
        if (beat_fire) begin
          if ((beat_q + LEN_W'(1)) == len_q) begin
            state_d = ST_DRAIN;
            timer_d = '0;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        timer_d = timer_q + TW'(1);
        // Completion wins over timeout if the final result lands on the last timer cycle.
        if (res_d >= len_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      res_q     <= '0;
      timer_q   <= '0;
      wloaded_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      res_q     <= res_d;
      timer_q   <= timer_d;
      wloaded_q <= wloaded_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign timeout_o = timeout_q;
  assign wloaded_o = wloaded_q;

endmodule
